// File: rtl/aes_pkg.sv
// Shared AES constants and types.
// Used by the key expansion and the round blocks, so the block width, the
// round-key counts per key size and the round-index type live in one place.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES128_NUM_RK = 11;
  localparam int AES192_NUM_RK = 13;
  localparam int AES256_NUM_RK = 15;

  // Wide enough to index the largest key schedule (15 round keys).
  localparam int AES_RK_IDX_W  = 4;

  typedef logic [AES_RK_IDX_W-1:0] aes_round_idx_t;

endpackage

// File: rtl/aes_add_round_key_pipe_if.sv
// Stream bus for the AddRoundKey stage.
// Carries the input beat (valid/ready, state, round) and the output beat
// (valid/ready, state, round, err) in one bundle.
//   master : upstream producer plus downstream consumer (drives in_* and out_ready)
//   slave  : the AddRoundKey stage (drives in_ready and out_*)
interface aes_add_round_key_pipe_if
  import aes_pkg::*;
#(
  parameter int DATA_W    = AES_BLOCK_W,
  parameter int KEY_IDX_W = AES_RK_IDX_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_state;
  logic [KEY_IDX_W-1:0] in_round;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_state;
  logic [KEY_IDX_W-1:0] out_round;
  logic                 out_err;

  modport master (
    output in_valid, in_state, in_round, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_err
  );

  modport slave (
    input  in_valid, in_state, in_round, out_ready,
    output in_ready, out_valid, out_state, out_round, out_err
  );

endinterface

// File: rtl/aes_skid_buffer.sv
// Two-entry valid/ready register slice.
// The upstream ready is a plain register (no path from i_dn_ready), and a
// beat taken while the main register is stalled parks in the skid register.
//   clk, rst_n  : clock, asynchronous active-low reset (control bits only)
//   i_up_valid  : upstream beat valid
//   o_up_ready  : slice can take a beat (skid register empty)
//   i_up_data   : upstream beat payload
//   o_dn_valid  : main register holds a beat
//   i_dn_ready  : downstream takes the main beat this cycle
//   o_dn_data   : main register payload
module aes_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_up_valid,
  output logic         o_up_ready,
  input  logic [W-1:0] i_up_data,
  output logic         o_dn_valid,
  input  logic         i_dn_ready,
  output logic [W-1:0] o_dn_data
);

  logic         r_main_vld;
  logic         r_skid_vld;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;

  logic         w_up_fire;
  logic         w_main_load;

  assign o_up_ready  = ~r_skid_vld;
  assign o_dn_valid  = r_main_vld;
  assign o_dn_data   = r_main_data;

  assign w_up_fire   = i_up_valid & ~r_skid_vld;
  // Main register can be (re)written: it is empty or its beat leaves this edge.
  assign w_main_load = ~r_main_vld | i_dn_ready;

  // A full skid implies a full main register, so when main frees up the skid
  // beat moves first; upstream is not ready in that cycle, so nothing is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_load) begin
      if (r_skid_vld) begin
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_main_vld <= w_up_fire;
      end
    end else if (w_up_fire) begin
      r_skid_vld <= 1'b1;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_main_load) begin
      if (r_skid_vld) begin
        r_main_data <= r_skid_data;
      end else if (w_up_fire) begin
        r_main_data <= i_up_data;
      end
    end else if (w_up_fire) begin
      r_skid_data <= i_up_data;
    end
  end

endmodule

// File: rtl/aes_add_round_key_pipe.sv
// AES AddRoundKey stage with a loadable round-key bank.
// Each accepted beat is XORed with the round key selected by its round index
// and passed through a two-entry skid slice. A missing key or an index past
// the bank leaves the state untouched and flags out_err; the beat still flows.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_clr     : invalidate all stored keys
//   key_wr_en   : write key_wr_data into bank[key_wr_idx] (ignored if out of range)
//   key_wr_idx  : key bank write index
//   key_wr_data : round key to store
//   bus         : stream bus, slave side (in_* beats in, out_* results out)
module aes_add_round_key_pipe
  import aes_pkg::*;
#(
  parameter int DATA_W    = AES_BLOCK_W,
  parameter int NUM_KEYS  = AES128_NUM_RK,
  parameter int KEY_IDX_W = AES_RK_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_clr,
  input  logic                 key_wr_en,
  input  logic [KEY_IDX_W-1:0] key_wr_idx,
  input  logic [DATA_W-1:0]    key_wr_data,
  aes_add_round_key_pipe_if.slave bus
);

  localparam int BEAT_W = 1 + KEY_IDX_W + DATA_W;
  localparam logic [KEY_IDX_W:0] NUM_KEYS_L = (KEY_IDX_W + 1)'(NUM_KEYS);

  logic [DATA_W-1:0]    r_key [NUM_KEYS];
  logic [NUM_KEYS-1:0]  r_key_vld;

  logic                 w_wr_ok;
  logic [KEY_IDX_W-1:0] w_wr_sel;
  logic                 w_rd_ok;
  logic [KEY_IDX_W-1:0] w_rd_sel;
  logic                 w_key_hit;
  logic [DATA_W-1:0]    w_result;
  logic [BEAT_W-1:0]    w_beat_in;
  logic [BEAT_W-1:0]    w_beat_out;

  function automatic logic idx_in_range(input logic [KEY_IDX_W-1:0] idx);
    return {1'b0, idx} < NUM_KEYS_L;
  endfunction

  function automatic logic [DATA_W-1:0] add_round_key(
    input logic              hit,
    input logic [DATA_W-1:0] state,
    input logic [DATA_W-1:0] key
  );
    return hit ? (state ^ key) : state;
  endfunction

  // Key bank write port. Indices are forced in range before they reach the
  // array so an ignored write never produces an out-of-bounds select.
  assign w_wr_ok  = key_wr_en & idx_in_range(key_wr_idx);
  assign w_wr_sel = w_wr_ok ? key_wr_idx : '0;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_key[w_wr_sel] <= key_wr_data;
    end
  end

  // Clear first, then the write sets its own bit: clear+write leaves exactly
  // the written index valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_vld <= '0;
    end else begin
      if (key_clr) begin
        r_key_vld <= '0;
      end
      if (w_wr_ok) begin
        r_key_vld[w_wr_sel] <= 1'b1;
      end
    end
  end

  // Key select and XOR, from the bank as it stands before the accepting edge,
  // so a same-cycle write to the selected index is not seen by this beat.
  assign w_rd_ok   = idx_in_range(bus.in_round);
  assign w_rd_sel  = w_rd_ok ? bus.in_round : '0;
  assign w_key_hit = w_rd_ok & r_key_vld[w_rd_sel];
  assign w_result  = add_round_key(w_key_hit, bus.in_state, r_key[w_rd_sel]);
  assign w_beat_in = {~w_key_hit, bus.in_round, w_result};

  // Output register slice.
  aes_skid_buffer #(.W(BEAT_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_up_valid (bus.in_valid),
    .o_up_ready (bus.in_ready),
    .i_up_data  (w_beat_in),
    .o_dn_valid (bus.out_valid),
    .i_dn_ready (bus.out_ready),
    .o_dn_data  (w_beat_out)
  );

  assign {bus.out_err, bus.out_round, bus.out_state} = w_beat_out;

endmodule

// File: tb/tb_aes_add_round_key_pipe.sv
// Bench for aes_add_round_key_pipe: scoreboard of expected beats built from a
// reference key bank, plus directed checks on handshake and reset behaviour.
module tb_aes_add_round_key_pipe;
  import aes_pkg::*;

  localparam int DATA_W    = 128;
  localparam int NUM_KEYS  = 11;
  localparam int KEY_IDX_W = 4;

  typedef struct packed {
    logic           err;
    aes_round_idx_t round;
    logic [127:0]   state;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 key_clr = 1'b0;
  logic                 key_wr_en = 1'b0;
  logic [KEY_IDX_W-1:0] key_wr_idx = '0;
  logic [DATA_W-1:0]    key_wr_data = '0;

  always #5 clk = ~clk;

  aes_add_round_key_pipe_if #(.DATA_W(DATA_W), .KEY_IDX_W(KEY_IDX_W)) bus ();

  aes_add_round_key_pipe #(
    .DATA_W    (DATA_W),
    .NUM_KEYS  (NUM_KEYS),
    .KEY_IDX_W (KEY_IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_clr     (key_clr),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .bus         (bus)
  );

  int           n_chk  = 0;
  int           n_pass = 0;
  int           n_out  = 0;
  beat_t        sb[$];
  logic [127:0] mkey[16];
  logic [15:0]  mvld = '0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic beat_t model(input logic [127:0] s, input aes_round_idx_t r);
    beat_t b;
    b.round = r;
    if (int'(r) < NUM_KEYS && mvld[r]) begin
      b.state = s ^ mkey[r];
      b.err   = 1'b0;
    end else begin
      b.state = s;
      b.err   = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Inputs are stable mid-cycle, so the negedge sees exactly what the next
  // posedge will act on: deliveries are popped, accepts pushed using the
  // reference bank before this cycle's key write is applied.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_out", 128'(bus.out_valid), 128'(0));
        end else begin
          beat_t e;
          e = sb.pop_front();
          check_eq("sb_state", bus.out_state, e.state);
          check_eq("sb_round", 128'(bus.out_round), 128'(e.round));
          check_eq("sb_err",   128'(bus.out_err),   128'(e.err));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_state, bus.in_round));
      if (key_clr) mvld = '0;
      if (key_wr_en && int'(key_wr_idx) < NUM_KEYS) begin
        mkey[key_wr_idx] = key_wr_data;
        mvld[key_wr_idx] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input aes_round_idx_t idx, input logic [127:0] d);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = d;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic send(input logic [127:0] s, input aes_round_idx_t r);
    bus.in_valid = 1'b1;
    bus.in_state = s;
    bus.in_round = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] s, s2, k1, k2, held;
    int n0, drops;

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_round  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check_eq("rst_in_ready",  128'(bus.in_ready),  128'(1));
    rst_n = 1'b1;
    tick();

    // 1: FIPS-197 round-0 vector, one-cycle latency
    write_key(4'd0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    send(128'h3243f6a8_885a308d_313198a2_e0370734, 4'd0);
    check_eq("t1_valid", 128'(bus.out_valid), 128'(1));
    check_eq("t1_state", bus.out_state, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
    check_eq("t1_err",   128'(bus.out_err), 128'(0));
    tick();

    // 2: streaming 20 beats, rounds cycling 0..10
    for (int r = 1; r < NUM_KEYS; r++) write_key(4'(r), rand128());
    n0 = n_out;
    drops = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_state = rand128();
      bus.in_round = 4'(i % NUM_KEYS);
      if (!bus.in_ready) drops++;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check_eq("t2_ready_drops", 128'(drops), 128'(0));
    check_eq("t2_out_count",   128'(n_out - n0), 128'(20));

    // 3: backpressure, skid fill, hold, drain
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_state  = rand128(); bus.in_round = 4'd1;
    tick();
    bus.in_state  = rand128(); bus.in_round = 4'd2;
    tick();
    check_eq("t3_ready_low", 128'(bus.in_ready),  128'(0));
    check_eq("t3_valid",     128'(bus.out_valid), 128'(1));
    held = bus.out_state;
    bus.in_state  = rand128(); bus.in_round = 4'd3;
    tick();
    check_eq("t3_hold_state", bus.out_state, held);
    check_eq("t3_still_low",  128'(bus.in_ready), 128'(0));
    bus.out_ready = 1'b1;
    tick();
    check_eq("t3_ready_back", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();

    // 4: missing key and out-of-range index
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    s = rand128();
    send(s, 4'd5);
    check_eq("t4_nokey_state", bus.out_state, s);
    check_eq("t4_nokey_err",   128'(bus.out_err), 128'(1));
    write_key(4'd12, rand128());
    s = rand128();
    send(s, 4'd12);
    check_eq("t4_oor_state", bus.out_state, s);
    check_eq("t4_oor_err",   128'(bus.out_err), 128'(1));
    tick();

    // 5: same-cycle key write uses old key; clear+write
    k1 = rand128();
    k2 = rand128();
    write_key(4'd3, k1);
    s = rand128();
    key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = k2;
    bus.in_valid = 1'b1; bus.in_state = s; bus.in_round = 4'd3;
    tick();
    key_wr_en = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("t5_old_key", bus.out_state, s ^ k1);
    s2 = rand128();
    send(s2, 4'd3);
    check_eq("t5_new_key", bus.out_state, s2 ^ k2);
    key_clr = 1'b1; key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = k1;
    tick();
    key_clr = 1'b0; key_wr_en = 1'b0;
    for (int r = 0; r < NUM_KEYS; r++) begin
      send(rand128(), 4'(r));
      check_eq($sformatf("t5_clr_err%0d", r), 128'(bus.out_err), 128'(r != 3));
    end
    tick();

    // 6: reset with both buffers full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_state  = rand128(); bus.in_round = 4'd3;
    tick();
    bus.in_state  = rand128(); bus.in_round = 4'd3;
    tick();
    bus.in_valid = 1'b0;
    check_eq("t6_full", 128'(bus.in_ready), 128'(0));
    #2;
    rst_n = 1'b0;
    sb.delete();
    mvld = '0;
    #1;
    check_eq("t6_rst_valid", 128'(bus.out_valid), 128'(0));
    check_eq("t6_rst_ready", 128'(bus.in_ready),  128'(1));
    tick(); tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    k1 = rand128();
    write_key(4'd0, k1);
    s = rand128();
    send(s, 4'd0);
    check_eq("t6_new_valid", 128'(bus.out_valid), 128'(1));
    check_eq("t6_new_state", bus.out_state, s ^ k1);
    check_eq("t6_new_round", 128'(bus.out_round), 128'(0));
    tick();
    check_eq("t6_no_stale", 128'(bus.out_valid), 128'(0));
    tick();

    check_eq("sb_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
